sram_access_ctrl: RTL
=====================

SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, word width; ADDR_W, default 5, address width; NWORDS, default 32, wordline count.
REQ-002 SHALL have port srclkpos, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have ports req_valid, input, 1, and req_ready, output, 1: request handshake.
REQ-005 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-006 SHALL have ports addrA and addrB, input, ADDR_W each: binary port addresses.
REQ-007 SHALL have port wdata, input, DATA_W: write data.
REQ-008 SHALL have ports wordA and wordB, output, NWORDS each: one-hot wordlines to the array.
REQ-009 SHALL have ports ReadEn and WriteEn, output, 1 each: array enables.
REQ-010 SHALL have port sram_din, output, DATA_W: array write data.
REQ-011 SHALL have ports outA and outB, input, DATA_W each: array read data.
REQ-012 SHALL have ports rsp_valid, output, 1, and rsp_ready, input, 1: response handshake.
REQ-013 SHALL have ports rdataA and rdataB, output, DATA_W each, and rsp_err, output, 1.

Function
REQ-014 SHALL implement the FSM IDLE -> DECODE -> ACCESS -> RESP -> IDLE.
REQ-015 SHALL assert req_ready only in IDLE; a request is accepted on req_valid & req_ready, capturing req_we, both addresses and wdata in registers.
REQ-016 In DECODE (accept+1), SHALL drive registered one-hot wordA/wordB and sram_din; ReadEn and WriteEn SHALL be 0.
REQ-017 In ACCESS (accept+2), SHALL assert exactly one of ReadEn/WriteEn for exactly one cycle while holding wordlines and sram_din stable.
REQ-018 In RESP (accept+3), SHALL register outA/outB into rdataA/rdataB on reads and assert rsp_valid, holding all response outputs until rsp_valid & rsp_ready, then return to IDLE.
REQ-019 Wordlines SHALL be all-zero in IDLE and RESP.
REQ-020 Address 0 is hardwired zero: a read of address 0 SHALL return 16'h0000 on that port, and a write with either address 0 SHALL still complete, but that port's wordline SHALL be suppressed.
REQ-021 Address NWORDS-1 (31) is not addressable: such a request SHALL skip ACCESS (no enable asserted), go DECODE -> RESP with rsp_err=1 and rdata 0.
REQ-022 addrA == addrB SHALL be legal: identical one-hot on both wordlines.
REQ-023 On writes, rdataA/rdataB SHALL be 0 and rsp_err 0.
REQ-024 Minimum request-to-request spacing SHALL be 4 cycles; back-to-back throughput is 1 access per 4 cycles with rsp_ready held high.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE, and drive wordA=wordB=0, ReadEn=WriteEn=0, sram_din=0, rsp_valid=0, rdataA=rdataB=0, rsp_err=0, and req_ready=0 while rst is high.
REQ-026 After deassertion, req_ready SHALL rise on the first clock edge; a reset during ACCESS SHALL drop the enable without completing the operation.

Structure
REQ-027 The package sram_pkg SHALL hold DATA_W, ADDR_W and NWORDS, and the state enum typedef.
REQ-028 The one-hot decode SHALL be a sub-module onehot_decoder (ADDR_W in, NWORDS out, plus an enable input), instantiated twice.
REQ-029 The controller SHALL contain no storage array; it SHALL only register requests and responses.

Verification
REQ-030 Write addrA=addrB=5, wdata=16'hBEEF: at accept+2, wordA=wordB=32'h20 and WriteEn=1 for one cycle; rsp_valid at +3 with rsp_err=0.
REQ-031 Read addrA=5, addrB=7 with an array model returning BEEF/1234: ReadEn=1 at +2 only; at +3, rdataA=16'hBEEF and rdataB=16'h1234.
REQ-032 Read addrA=0, addrB=31: no ReadEn is asserted; rsp_err=1 and rdataA=rdataB=0.
REQ-033 Hold rsp_ready=0 for 5 cycles: rsp_valid and rdata stay stable, req_ready stays 0, and a new req_valid is not accepted.
REQ-034 Assert rst during ACCESS of a write: WriteEn falls asynchronously and wordlines go to 0; after release, req_ready=1 on the next edge.
REQ-035 Issue 10 random back-to-back requests with rsp_ready=1: accepts occur every 4 cycles and at most one enable is active in any cycle.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared sizing and state encoding for the SRAM access controller.
package sram_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int NWORDS = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/onehot_decoder.sv
// Binary address to one-hot wordline decode, gated by an enable.
module onehot_decoder #(
    parameter int ADDR_W = 5,
    parameter int NWORDS = 32
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [NWORDS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NWORDS; i++) begin
            onehot[i] = en && (addr == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/sram_access_ctrl.sv
// Request/response sequencer for a dual-wordline SRAM array: decode, one-cycle
// access strobe, then a held response until the consumer takes it.
module sram_access_ctrl #(
    parameter int DATA_W = sram_pkg::DATA_W,
    parameter int ADDR_W = sram_pkg::ADDR_W,
    parameter int NWORDS = sram_pkg::NWORDS
) (
    input  logic              srclkpos,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [ADDR_W-1:0] addrB,
    input  logic [DATA_W-1:0] wdata,
    output logic [NWORDS-1:0] wordA,
    output logic [NWORDS-1:0] wordB,
    output logic              ReadEn,
    output logic              WriteEn,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] outA,
    input  logic [DATA_W-1:0] outB,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rdataA,
    output logic [DATA_W-1:0] rdataB,
    output logic              rsp_err
);
    import sram_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_BAD = ADDR_W'(NWORDS - 1);

    state_e              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [NWORDS-1:0]   word_a_q, word_a_d, word_b_q, word_b_d;
    logic                read_en_q, read_en_d, write_en_q, write_en_d;
    logic [DATA_W-1:0]   sram_din_q, sram_din_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;

    // The top word is unbacked; address 0 is a hardwired-zero row.
    logic              bad_req;
    logic [NWORDS-1:0] dec_a, dec_b;

    assign bad_req = (addrA == ADDR_BAD) || (addrB == ADDR_BAD);

    onehot_decoder #(.ADDR_W(ADDR_W), .NWORDS(NWORDS)) u_dec_a (
        .en     (!bad_req && (addrA != '0)),
        .addr   (addrA),
        .onehot (dec_a)
    );

    onehot_decoder #(.ADDR_W(ADDR_W), .NWORDS(NWORDS)) u_dec_b (
        .en     (!bad_req && (addrB != '0)),
        .addr   (addrB),
        .onehot (dec_b)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        we_d        = we_q;
        err_d       = err_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        word_a_d    = word_a_q;
        word_b_d    = word_b_q;
        read_en_d   = 1'b0;
        write_en_d  = 1'b0;
        sram_din_d  = sram_din_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    we_d        = req_we;
                    err_d       = bad_req;
                    addr_a_d    = addrA;
                    addr_b_d    = addrB;
                    word_a_d    = dec_a;
                    word_b_d    = dec_b;
                    sram_din_d  = req_we ? wdata : '0;
                    state_d     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (err_q) begin
                    word_a_d    = '0;
                    word_b_d    = '0;
                    sram_din_d  = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rdata_a_d   = '0;
                    rdata_b_d   = '0;
                    state_d     = ST_RESP;
                end else begin
                    read_en_d  = !we_q;
                    write_en_d = we_q;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                word_a_d    = '0;
                word_b_d    = '0;
                sram_din_d  = '0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rdata_a_d   = (!we_q && addr_a_q != '0) ? outA : '0;
                rdata_b_d   = (!we_q && addr_b_q != '0) ? outB : '0;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rdata_a_d   = '0;
                    rdata_b_d   = '0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge srclkpos or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            word_a_q    <= '0;
            word_b_q    <= '0;
            read_en_q   <= 1'b0;
            write_en_q  <= 1'b0;
            sram_din_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            we_q        <= we_d;
            err_q       <= err_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            word_a_q    <= word_a_d;
            word_b_q    <= word_b_d;
            read_en_q   <= read_en_d;
            write_en_q  <= write_en_d;
            sram_din_q  <= sram_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
        end
    end

    assign req_ready = req_ready_q;
    assign wordA     = word_a_q;
    assign wordB     = word_b_q;
    assign ReadEn    = read_en_q;
    assign WriteEn   = write_en_q;
    assign sram_din  = sram_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rdataA    = rdata_a_q;
    assign rdataB    = rdata_b_q;

endmodule
